// File: rtl/prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem -- loadable program memory with a registered instruction fetch port.
//
// A small FSM (IDLE -> LOAD -> DONE -> IDLE) streams a program into the word
// array through a valid/ready load port. While idle, a fetch presents the word
// at PC on A (opcode field) and D (immediate field) one cycle later. During a
// load the fetch port is blocked and A/D/instr_valid read as zero (NOP).
//
// Parameters
//   ADDR_W  : PC / address width, DEPTH = 2**ADDR_W words
//   OP_W    : opcode field width (upper bits of a word)
//   IMM_W   : immediate field width (lower bits of a word)
//
// Ports
//   CLK          in   clock, everything changes on the rising edge
//   RST          in   synchronous active-high reset (memory array untouched)
//   PC           in   fetch address
//   fetch_en     in   fetch request for PC this cycle
//   A            out  registered opcode field
//   D            out  registered immediate field
//   instr_valid  out  A/D hold the word from an accepted fetch
//   ld_start     in   begin a program load
//   ld_valid     in   ld_data valid
//   ld_data      in   program word to write
//   ld_last      in   final word of the load
//   ld_ready     out  load word accepted this cycle when ld_valid is high
//   ld_done      out  one-cycle pulse when a load completes
//
// Optional feature, macro PROG_MEM_PARITY_EN:
//   stores an even-parity bit with every word and adds
//   ld_par_inv   in   invert the stored parity bit of the word being written
//   parity_err   out  registered with A/D, 1 when the fetched word fails parity
// ---------------------------------------------------------------------------
module prog_mem #(
   parameter int ADDR_W = 4,
   parameter int OP_W   = 4,
   parameter int IMM_W  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [ADDR_W-1:0]       PC,
   input  logic                    fetch_en,
   output logic [OP_W-1:0]         A,
   output logic [IMM_W-1:0]        D,
   output logic                    instr_valid,
   input  logic                    ld_start,
   input  logic                    ld_valid,
   input  logic [OP_W+IMM_W-1:0]   ld_data,
   input  logic                    ld_last,
   output logic                    ld_ready,
`ifdef PROG_MEM_PARITY_EN
   input  logic                    ld_par_inv,
   output logic                    parity_err,
`endif
   output logic                    ld_done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int W     = OP_W + IMM_W;
`ifdef PROG_MEM_PARITY_EN
   localparam int MEM_W = W + 1;   // parity bit stored in the MSB
`else
   localparam int MEM_W = W;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [IMM_W-1:0]  d_q, d_d;
   logic              valid_q, valid_d;
   logic [MEM_W-1:0]  mem_q [DEPTH];
   logic [MEM_W-1:0]  rd_word;
   logic [MEM_W-1:0]  wr_word;
   logic              wr_en;
`ifdef PROG_MEM_PARITY_EN
   logic              perr_q, perr_d;
`endif

   assign ld_ready = (state_q == S_LOAD);
   assign ld_done  = (state_q == S_DONE);
   // Reset wins over a load word presented in the same cycle.
   assign wr_en    = ld_ready && ld_valid && !RST;
   assign rd_word  = mem_q[PC];

`ifdef PROG_MEM_PARITY_EN
   // Even parity: XOR over data and parity bit is 0 for a clean word.
   assign wr_word  = {(^ld_data) ^ ld_par_inv, ld_data};
`else
   assign wr_word  = ld_data;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      d_d     = d_q;
      valid_d = valid_q;
`ifdef PROG_MEM_PARITY_EN
      perr_d  = perr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               // Load has priority over a simultaneous fetch request.
               state_d = S_LOAD;
               cnt_d   = '0;
               a_d     = '0;
               d_d     = '0;
               valid_d = 1'b0;
`ifdef PROG_MEM_PARITY_EN
               perr_d  = 1'b0;
`endif
            end else if (fetch_en) begin
               a_d     = rd_word[W-1:IMM_W];
               d_d     = rd_word[IMM_W-1:0];
               valid_d = 1'b1;
`ifdef PROG_MEM_PARITY_EN
               perr_d  = ^rd_word;
`endif
            end
         end
         S_LOAD: begin
            a_d     = '0;
            d_d     = '0;
            valid_d = 1'b0;
`ifdef PROG_MEM_PARITY_EN
            perr_d  = 1'b0;
`endif
            if (ld_valid) begin
               // The last address completes the load, so the counter never wraps.
               if (ld_last || (cnt_q == '1)) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: begin
            // DONE (and any unreachable code) returns to IDLE after one cycle.
            state_d = S_IDLE;
            a_d     = '0;
            d_d     = '0;
            valid_d = 1'b0;
`ifdef PROG_MEM_PARITY_EN
            perr_d  = 1'b0;
`endif
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block above.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         d_q     <= '0;
         valid_q <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         d_q     <= d_d;
         valid_q <= valid_d;
`ifdef PROG_MEM_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // NOTE: the word array has no reset; a program survives RST and an aborted
   // load keeps whatever words it had already written.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[cnt_q] <= wr_word;
      end
   end

   assign A           = a_q;
   assign D           = d_q;
   assign instr_valid = valid_q;
`ifdef PROG_MEM_PARITY_EN
   assign parity_err  = perr_q;
`endif

endmodule
